// File: rtl/ahb_apb_bridge_param.sv
// AHB-Lite to APB3 bridge with NUM_SLAVES address-decoded regions, slave wait states,
// slave/decode error reporting as a two-cycle AHB ERROR, and an optional wait-state timeout.
module ahb_apb_bridge_param #(
    parameter int                NUM_SLAVES  = 3,
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(32'h8000_0000),
    parameter int                REGION_BITS = 26,
    parameter int                TIMEOUT     = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Hwrite,
    input  logic                  Hreadyin,
    input  logic [1:0]            Htrans,
    input  logic [ADDR_W-1:0]     Haddr,
    input  logic [DATA_W-1:0]     Hwdata,
    input  logic [DATA_W-1:0]     Prdata,
    input  logic                  Pready,
    input  logic                  Pslverr,
    output logic [NUM_SLAVES-1:0] Pselx,
    output logic [ADDR_W-1:0]     Paddr,
    output logic [DATA_W-1:0]     Pwdata,
    output logic                  Pwrite,
    output logic                  Penable,
    output logic                  Hreadyout,
    output logic [1:0]            Hresp,
    output logic [DATA_W-1:0]     Hrdata
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WWAIT  = 3'd1,
        S_SETUP  = 3'd2,
        S_ACCESS = 3'd3,
        S_ERR1   = 3'd4,
        S_ERR2   = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [NUM_SLAVES-1:0]   sel_q, sel_d;
    logic [NUM_SLAVES-1:0]   pselx_q;
    logic [ADDR_W-1:0]       paddr_q;
    logic [DATA_W-1:0]       pwdata_q;
    logic                    pwrite_q;
    logic                    penable_q;
    logic                    hreadyout_q;
    logic [1:0]              hresp_q;
    logic [DATA_W-1:0]       hrdata_q;

    logic [ADDR_W-1:0]       offset_s;
    logic [ADDR_W-1:0]       idx_s;
    logic                    hit_s;
    logic [NUM_SLAVES-1:0]   dec_sel_s;
    logic                    accept_s;
    logic                    rd_done_s;

    assign accept_s = Hreadyin & hreadyout_q & Htrans[1];

    // Region decode: unsigned, full-width, so addresses below BASE_ADDR never wrap into a hit.
    always_comb begin
        offset_s = Haddr - BASE_ADDR;
        idx_s    = offset_s >> REGION_BITS;
        hit_s    = (Haddr >= BASE_ADDR) && (idx_s < ADDR_W'(NUM_SLAVES));
        for (int i = 0; i < NUM_SLAVES; i++) begin
            dec_sel_s[i] = hit_s && (idx_s == ADDR_W'(i));
        end
    end

    // Next-state, wait counter and captured slave select.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sel_d     = sel_q;
        rd_done_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    sel_d = dec_sel_s;
                    cnt_d = '0;
                    if (!hit_s) begin
                        state_d = S_ERR1;
                    end else if (Hwrite) begin
                        state_d = S_WWAIT;
                    end else begin
                        state_d = S_SETUP;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WWAIT: begin
                state_d = S_SETUP;
                cnt_d   = '0;
            end
            S_SETUP: begin
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                // A ready slave wins over an expiring timeout in the same cycle.
                if (Pready) begin
                    if (Pslverr) begin
                        state_d = S_ERR1;
                    end else begin
                        state_d   = S_IDLE;
                        rd_done_s = !pwrite_q;
                    end
                end else if ((TIMEOUT > 0) && (cnt_q == TO_LAST)) begin
                    state_d = S_ERR1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_ERR1: begin
                state_d = S_ERR2;
            end
            S_ERR2: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; bus outputs are derived from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            sel_q       <= '0;
            pselx_q     <= '0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pwrite_q    <= 1'b0;
            penable_q   <= 1'b0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 2'b00;
            hrdata_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            if ((state_q == S_IDLE) && accept_s) begin
                paddr_q  <= Haddr;
                pwrite_q <= Hwrite;
            end
            if (state_q == S_WWAIT) begin
                pwdata_q <= Hwdata;
            end
            if (rd_done_s) begin
                hrdata_q <= Prdata;
            end
            pselx_q     <= ((state_d == S_SETUP) || (state_d == S_ACCESS)) ? sel_d : '0;
            penable_q   <= (state_d == S_ACCESS);
            hreadyout_q <= (state_d == S_IDLE) || (state_d == S_ERR2);
            hresp_q     <= ((state_d == S_ERR1) || (state_d == S_ERR2)) ? 2'b01 : 2'b00;
        end
    end

    assign Pselx     = pselx_q;
    assign Paddr     = paddr_q;
    assign Pwdata    = pwdata_q;
    assign Pwrite    = pwrite_q;
    assign Penable   = penable_q;
    assign Hreadyout = hreadyout_q;
    assign Hresp     = hresp_q;
    assign Hrdata    = hrdata_q;

endmodule

// File: tb/tb_ahb_apb_bridge_param.sv
// Directed bench for ahb_apb_bridge_param (3 slaves, TIMEOUT=4): expected output
// snapshots are queued as each step is driven and compared once the clock edge has passed.
module tb_ahb_apb_bridge_param;

    logic        clk;
    logic        rst;
    logic        Hwrite;
    logic        Hreadyin;
    logic [1:0]  Htrans;
    logic [31:0] Haddr;
    logic [31:0] Hwdata;
    logic [31:0] Prdata;
    logic        Pready;
    logic        Pslverr;
    logic [2:0]  Pselx;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic        Pwrite;
    logic        Penable;
    logic        Hreadyout;
    logic [1:0]  Hresp;
    logic [31:0] Hrdata;

    ahb_apb_bridge_param #(
        .NUM_SLAVES (3),
        .ADDR_W     (32),
        .DATA_W     (32),
        .BASE_ADDR  (32'h8000_0000),
        .REGION_BITS(26),
        .TIMEOUT    (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .Hwrite   (Hwrite),
        .Hreadyin (Hreadyin),
        .Htrans   (Htrans),
        .Haddr    (Haddr),
        .Hwdata   (Hwdata),
        .Prdata   (Prdata),
        .Pready   (Pready),
        .Pslverr  (Pslverr),
        .Pselx    (Pselx),
        .Paddr    (Paddr),
        .Pwdata   (Pwdata),
        .Pwrite   (Pwrite),
        .Penable  (Penable),
        .Hreadyout(Hreadyout),
        .Hresp    (Hresp),
        .Hrdata   (Hrdata)
    );

    typedef struct packed {
        logic [2:0]  sel;
        logic        pen;
        logic        hro;
        logic [1:0]  hresp;
        logic        pwrite;
        logic [31:0] paddr;
        logic [31:0] pwdata;
        logic [31:0] hrdata;
    } outs_t;

    outs_t exp_q[$];
    string tag_q[$];
    int    n_pass  = 0;
    int    n_total = 0;

    // Bench model of the held APB/AHB data registers.
    logic [31:0] m_paddr;
    logic [31:0] m_pwdata;
    logic [31:0] m_hrdata;
    logic        m_pwrite;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input string tag, input logic [2:0] sel, input logic pen,
                        input logic hro, input logic [1:0] hresp);
        outs_t e;
        outs_t o;
        string t;
        e.sel    = sel;
        e.pen    = pen;
        e.hro    = hro;
        e.hresp  = hresp;
        e.pwrite = m_pwrite;
        e.paddr  = m_paddr;
        e.pwdata = m_pwdata;
        e.hrdata = m_hrdata;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        @(negedge clk);
        o = {Pselx, Penable, Hreadyout, Hresp, Pwrite, Paddr, Pwdata, Hrdata};
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        n_total = n_total + 1;
        assert (o === e) n_pass = n_pass + 1;
        else $error("FAIL %s: observed sel=%b pen=%b hro=%b hresp=%b pwrite=%b paddr=%h pwdata=%h hrdata=%h expected sel=%b pen=%b hro=%b hresp=%b pwrite=%b paddr=%h pwdata=%h hrdata=%h",
                    t, o.sel, o.pen, o.hro, o.hresp, o.pwrite, o.paddr, o.pwdata, o.hrdata,
                    e.sel, e.pen, e.hro, e.hresp, e.pwrite, e.paddr, e.pwdata, e.hrdata);
    endtask

    initial begin
        rst = 1'b1; Htrans = 2'b00; Hwrite = 1'b0; Hreadyin = 1'b1; Haddr = 32'h0;
        Hwdata = 32'h0; Prdata = 32'h0; Pready = 1'b1; Pslverr = 1'b0;
        m_paddr = 32'h0; m_pwdata = 32'h0; m_hrdata = 32'h0; m_pwrite = 1'b0;
        step("reset", 3'b000, 1'b0, 1'b1, 2'b00);
        rst = 1'b0;
        step("idle", 3'b000, 1'b0, 1'b1, 2'b00);

        // BUSY and a NONSEQ with Hreadyin low are both ignored
        Htrans = 2'b01; Haddr = 32'h8400_0000;
        step("busy_ignored", 3'b000, 1'b0, 1'b1, 2'b00);
        Htrans = 2'b10; Hreadyin = 1'b0;
        step("hreadyin_low", 3'b000, 1'b0, 1'b1, 2'b00);
        Hreadyin = 1'b1;

        // single read, slave 1
        Haddr = 32'h8400_0010; Prdata = 32'hCAFE_0001;
        m_paddr = 32'h8400_0010; m_pwrite = 1'b0;
        step("rd_setup", 3'b010, 1'b0, 1'b0, 2'b00);
        Htrans = 2'b00;
        step("rd_access", 3'b010, 1'b1, 1'b0, 2'b00);
        Htrans = 2'b10; Haddr = 32'h8000_0008;
        m_hrdata = 32'hCAFE_0001;
        step("rd_done", 3'b000, 1'b0, 1'b1, 2'b00);

        // back-to-back read accepted at T+3
        Prdata = 32'hCAFE_0002; m_paddr = 32'h8000_0008;
        step("b2b_setup", 3'b001, 1'b0, 1'b0, 2'b00);
        Htrans = 2'b00;
        step("b2b_access", 3'b001, 1'b1, 1'b0, 2'b00);
        m_hrdata = 32'hCAFE_0002;
        step("b2b_done", 3'b000, 1'b0, 1'b1, 2'b00);

        // write with three wait states, slave 2
        Htrans = 2'b10; Hwrite = 1'b1; Haddr = 32'h8800_0004; Pready = 1'b0;
        m_paddr = 32'h8800_0004; m_pwrite = 1'b1;
        step("wr_wwait", 3'b000, 1'b0, 1'b0, 2'b00);
        Htrans = 2'b00; Hwrite = 1'b0; Hwdata = 32'h1234_5678; m_pwdata = 32'h1234_5678;
        step("wr_setup", 3'b100, 1'b0, 1'b0, 2'b00);
        Hwdata = 32'h0;
        for (int i = 0; i < 4; i++) step("wr_access", 3'b100, 1'b1, 1'b0, 2'b00);
        Pready = 1'b1;
        step("wr_done", 3'b000, 1'b0, 1'b1, 2'b00);

        // slave error on read; transfer offered during ERR2 is discarded
        Htrans = 2'b10; Hwrite = 1'b0; Haddr = 32'h8000_0000; Pslverr = 1'b1;
        Prdata = 32'hDEAD_BEEF; m_paddr = 32'h8000_0000; m_pwrite = 1'b0;
        step("se_setup", 3'b001, 1'b0, 1'b0, 2'b00);
        Htrans = 2'b00;
        step("se_access", 3'b001, 1'b1, 1'b0, 2'b00);
        step("se_err1", 3'b000, 1'b0, 1'b0, 2'b01);
        Htrans = 2'b10; Haddr = 32'h8400_0000; Pslverr = 1'b0;
        step("se_err2", 3'b000, 1'b0, 1'b1, 2'b01);
        step("se_discard", 3'b000, 1'b0, 1'b1, 2'b00);

        // decode miss above the last region
        Haddr = 32'h8C00_0000; m_paddr = 32'h8C00_0000;
        step("miss_err1", 3'b000, 1'b0, 1'b0, 2'b01);
        Htrans = 2'b00;
        step("miss_err2", 3'b000, 1'b0, 1'b1, 2'b01);
        step("miss_idle", 3'b000, 1'b0, 1'b1, 2'b00);

        // decode miss just below BASE_ADDR (write never reaches WWAIT)
        Htrans = 2'b10; Hwrite = 1'b1; Haddr = 32'h7FFF_FFFC; Hwdata = 32'hFFFF_0000;
        m_paddr = 32'h7FFF_FFFC; m_pwrite = 1'b1;
        step("low_err1", 3'b000, 1'b0, 1'b0, 2'b01);
        Htrans = 2'b00; Hwrite = 1'b0;
        step("low_err2", 3'b000, 1'b0, 1'b1, 2'b01);
        step("low_idle", 3'b000, 1'b0, 1'b1, 2'b00);

        // timeout: four ACCESS cycles with Pready low, then ERROR
        Htrans = 2'b10; Haddr = 32'h8400_0000; Pready = 1'b0; Prdata = 32'h0F0F_0F0F;
        m_paddr = 32'h8400_0000; m_pwrite = 1'b0;
        step("to_setup", 3'b010, 1'b0, 1'b0, 2'b00);
        Htrans = 2'b00;
        for (int i = 0; i < 4; i++) step("to_access", 3'b010, 1'b1, 1'b0, 2'b00);
        step("to_err1", 3'b000, 1'b0, 1'b0, 2'b01);
        step("to_err2", 3'b000, 1'b0, 1'b1, 2'b01);
        step("to_idle", 3'b000, 1'b0, 1'b1, 2'b00);

        // Pready on the fourth ACCESS cycle beats the timeout
        Htrans = 2'b10; Haddr = 32'h8400_0020; Prdata = 32'h5555_AAAA;
        m_paddr = 32'h8400_0020;
        step("tr_setup", 3'b010, 1'b0, 1'b0, 2'b00);
        Htrans = 2'b00;
        for (int i = 0; i < 4; i++) step("tr_access", 3'b010, 1'b1, 1'b0, 2'b00);
        Pready = 1'b1; m_hrdata = 32'h5555_AAAA;
        step("tr_done", 3'b000, 1'b0, 1'b1, 2'b00);

        // reset pulse mid-ACCESS
        Htrans = 2'b10; Haddr = 32'h8800_0000; Pready = 1'b0;
        m_paddr = 32'h8800_0000;
        step("rs_setup", 3'b100, 1'b0, 1'b0, 2'b00);
        Htrans = 2'b00;
        step("rs_access1", 3'b100, 1'b1, 1'b0, 2'b00);
        step("rs_access2", 3'b100, 1'b1, 1'b0, 2'b00);
        rst = 1'b1;
        m_paddr = 32'h0; m_pwdata = 32'h0; m_hrdata = 32'h0; m_pwrite = 1'b0;
        step("rs_pulse1", 3'b000, 1'b0, 1'b1, 2'b00);
        step("rs_pulse2", 3'b000, 1'b0, 1'b1, 2'b00);
        rst = 1'b0; Pready = 1'b1;
        step("rs_idle", 3'b000, 1'b0, 1'b1, 2'b00);

        // read works again after reset
        Htrans = 2'b10; Haddr = 32'h8000_0004; Prdata = 32'h0BAD_F00D;
        m_paddr = 32'h8000_0004;
        step("post_setup", 3'b001, 1'b0, 1'b0, 2'b00);
        Htrans = 2'b00;
        step("post_access", 3'b001, 1'b1, 1'b0, 2'b00);
        m_hrdata = 32'h0BAD_F00D;
        step("post_done", 3'b000, 1'b0, 1'b1, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ahb_apb_bridge_param.md
# ahb_apb_bridge_param

Parametrised AHB-Lite to APB bridge: the next generation of the three-slave bridge, generalised to NUM_SLAVES decoded regions. Adds APB3 wait states (Pready), slave error propagation (Pslverr to a two-cycle AHB ERROR), decode-miss errors and a programmable wait-state timeout. It sits between the AHB interconnect and the peripheral APB segment, as a drop-in replacement for the fixed bridge top.

## Interface
Parameters:
- NUM_SLAVES, 3: number of APB slaves; width of Pselx; 1..16.
- ADDR_W, 32: address width.
- DATA_W, 32: data width.
- BASE_ADDR, 32'h8000_0000: start of slave region 0.
- REGION_BITS, 26: log2 of region size, so each region is 64 MB.
- TIMEOUT, 0: maximum number of consecutive ACCESS cycles with Pready=0; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- Hwrite  in  1  AHB transfer direction.
- Hreadyin  in  1  AHB bus ready.
- Htrans  in  2  AHB transfer type.
- Haddr  in  ADDR_W  AHB address.
- Hwdata  in  DATA_W  AHB write data, valid in the data phase.
- Prdata  in  DATA_W  APB read data.
- Pready  in  1  APB slave ready.
- Pslverr  in  1  APB slave error.
- Pselx  out  NUM_SLAVES  one-hot APB select.
- Paddr  out  ADDR_W  APB address.
- Pwdata  out  DATA_W  APB write data.
- Pwrite  out  1  APB direction.
- Penable  out  1  APB access phase.
- Hreadyout  out  1  AHB ready response.
- Hresp  out  2  AHB response: 00 OKAY, 01 ERROR.
- Hrdata  out  DATA_W  AHB read data.

One clock; reset is synchronous and active-high.

## Operation
- **Accept condition:** Hreadyin & Hreadyout & Htrans[1]. NONSEQ and SEQ are accepted; IDLE and BUSY are ignored with an OKAY response and Hreadyout held at 1.
- **On accept:** latch Haddr into Paddr and Hwrite into Pwrite.
- **Decode:** idx = (Haddr - BASE_ADDR) >> REGION_BITS. A hit requires Haddr >= BASE_ADDR and idx < NUM_SLAVES. The comparison is unsigned, at full ADDR_W.
- **States:** IDLE, WWAIT, SETUP, ACCESS, ERR1, ERR2.
- **IDLE:**
  - accept + miss -> ERR1.
  - accept + hit + write -> WWAIT.
  - accept + hit + read -> SETUP.
- **WWAIT:** capture Hwdata into Pwdata, then go to SETUP.
- **SETUP:** Pselx[idx]=1, Penable=0, then go to ACCESS.
- **ACCESS:** Pselx held, Penable=1.
  - Pready=0: stay in ACCESS; increment the wait counter.
  - Pready=1 & !Pslverr: go to IDLE. For reads, register Prdata into Hrdata.
  - Pready=1 & Pslverr: go to ERR1.
  - Timeout (counter == TIMEOUT-1 with Pready=0, TIMEOUT>0): go to ERR1.
  - The wait counter clears on entry to SETUP. Its width is clog2(TIMEOUT+1), minimum 1.
- **ERR1:** Hresp=01, Hreadyout=0, Pselx=0, Penable=0. Then go to ERR2.
- **ERR2:** Hresp=01, Hreadyout=1. Then go to IDLE. A transfer accepted in ERR2 is discarded: the master cancels it per AHB.
- **Output hold rules:**
  - Paddr, Pwrite and Pwdata hold their last values outside transfers.
  - Pselx and Penable are 0 in every state except SETUP/ACCESS.
- **Hreadyout:** 0 in WWAIT, SETUP, ACCESS and ERR1; 1 in IDLE and ERR2.
- **Hresp:** 00 in all states except ERR1/ERR2.
- **Hrdata:** updated only on successful read completion.
- **Reset:** all outputs go to reset values on the next edge, from any state. A transfer in progress is aborted with no completion cycle.
  - Pselx=0, Penable=0, Pwrite=0, Paddr=0, Pwdata=0, Hrdata=0.
  - Hreadyout=1, Hresp=00, state IDLE, wait counter=0.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- **Read, zero waits:**
  - T: accept.
  - T+1: SETUP.
  - T+2: ACCESS (Penable=1).
  - T+3: Hreadyout=1 with Hrdata valid; the next transfer can be accepted at T+3.
- **Write, zero waits:**
  - T: accept.
  - T+1: WWAIT (Hwdata sampled).
  - T+2: SETUP.
  - T+3: ACCESS.
  - T+4: Hreadyout=1.
- Each Pready=0 cycle adds one cycle of latency.
- **Back-to-back:** the bridge never issues overlapping APB transfers. Minimum spacing is 3 cycles (read) or 4 cycles (write) between accepts.
- **Error:** ERR1 follows ACCESS or the accept cycle directly, so the AHB ERROR response lasts exactly 2 cycles.
- **Timeout:** with TIMEOUT=N, the N-th consecutive Pready=0 ACCESS cycle is the last. A Pready=1 in that same cycle wins and the transfer completes normally.
- **Pslverr** is ignored while Pready=0.

## Test plan
- **Reset:** pulse rst high for 2 cycles mid-ACCESS -> next cycle Pselx=0, Penable=0, Paddr=0, Hreadyout=1, Hresp=00.
- **Single read:** read 32'h8400_0010, Pready=1, Prdata=32'hCAFE_0001 -> Pselx=3'b010 for 2 cycles, Penable high in the 2nd; at T+3 Hreadyout=1 and Hrdata=32'hCAFE_0001.
- **Write with waits:** write 32'h8800_0004 with data 32'h1234_5678, Pready low for 3 ACCESS cycles -> Pselx=3'b100, Pwdata=32'h1234_5678 from SETUP onward, Penable high for 4 cycles, Hreadyout=1 at T+7.
- **Slave error:** read 32'h8000_0000 with Pready=1 and Pslverr=1 in ACCESS -> Hresp=01 for 2 cycles, Hreadyout 0 then 1, Hrdata unchanged.
- **Decode miss:** NUM_SLAVES=3, access 32'h8C00_0000 -> no Pselx assertion; ERR1 at T+1, ERR2 at T+2.
- **Timeout:** TIMEOUT=4, Pready held at 0 -> exactly 4 ACCESS cycles, then a 2-cycle ERROR. Repeat with Pready=1 on the 4th cycle -> OKAY completion.
